// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Optional feature macro: MULDIV_SIGNED_EN (two's-complement operation).
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL_LO = 2'b00,
      OP_MUL_HI = 2'b01,
      OP_DIV_Q  = 2'b10,
      OP_DIV_R  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int FLAG_W  = 3;
   localparam int FLAG_Z  = 2;
   localparam int FLAG_N  = 1;
   localparam int FLAG_DZ = 0;

endpackage

// File: rtl/muldiv_shift_core.sv
// Radix-2 datapath: 2*WIDTH accumulator stepping either shift-add multiply
// or restoring divide, one iteration per asserted step.
module muldiv_shift_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic                 i_div_mode,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic [2*WIDTH-1:0]   o_acc_nxt
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_step;

   // One iteration: multiply adds into the upper half then shifts right;
   // divide shifts the partial remainder left and restores on borrow.
   always_comb begin
      w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
      w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff   = w_rem_sh - {1'b0, r_b};
      w_step   = r_acc;
      if (i_div_mode) begin
         if (w_diff[WIDTH] == 1'b0) begin
            w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (r_acc[0]) begin
            w_step = {w_sum, r_acc[WIDTH-1:1]};
         end else begin
            w_step = {1'b0, r_acc[2*WIDTH-1:1]};
         end
      end
   end

   assign o_acc_nxt = w_step;

   // Accumulator and operand register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= {(2*WIDTH){1'b0}};
         r_b   <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_acc <= {{WIDTH{1'b0}}, i_a};
         r_b   <= i_b;
      end else if (i_step) begin
         r_acc <= w_step;
      end else begin
         r_acc <= r_acc;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with Start/Busy/Done handshake.
// Define MULDIV_SIGNED_EN to honour i_signed (two's-complement operation).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [1:0]         i_op,
   input  logic               i_signed,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [WIDTH-1:0]   o_result,
   output logic [FLAG_W-1:0]  o_flags
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [CW-1:0]       r_count;
   op_e                 r_op;
   logic                r_busy;
   logic                r_done;
   logic [WIDTH-1:0]    r_result;
   logic [FLAG_W-1:0]   r_flags;

   logic                w_accept;
   logic                w_dz;
   logic                w_last;
   logic [WIDTH-1:0]    w_a_mag;
   logic [WIDTH-1:0]    w_b_mag;
   logic [2*WIDTH-1:0]  w_acc_nxt;
   logic [2*WIDTH-1:0]  w_prod;
   logic [WIDTH-1:0]    w_quo;
   logic [WIDTH-1:0]    w_rem;
   logic [WIDTH-1:0]    w_res;
   logic [WIDTH-1:0]    w_res_dz;

   function automatic logic [FLAG_W-1:0] make_flags(input logic [WIDTH-1:0] res,
                                                    input logic dz);
      logic [FLAG_W-1:0] f;
      f          = {FLAG_W{1'b0}};
      f[FLAG_Z]  = (res == {WIDTH{1'b0}});
      f[FLAG_N]  = res[WIDTH-1];
      f[FLAG_DZ] = dz;
      return f;
   endfunction

   assign w_accept = i_start && (r_state != ST_RUN);
   assign w_dz     = w_accept && i_op[1] && (i_b == {WIDTH{1'b0}});
   assign w_last   = (r_count == LAST);
   assign w_res_dz = i_op[0] ? i_a : {WIDTH{1'b1}};

`ifdef MULDIV_SIGNED_EN
   logic w_sa;
   logic w_sb;
   logic r_neg_p;
   logic r_neg_r;

   assign w_sa    = i_signed & i_a[WIDTH-1];
   assign w_sb    = i_signed & i_b[WIDTH-1];
   assign w_a_mag = w_sa ? -i_a : i_a;
   assign w_b_mag = w_sb ? -i_b : i_b;

   // Result signs captured with the operands; applied as the result is written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_neg_p <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_p <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
      end else begin
         r_neg_p <= r_neg_p;
         r_neg_r <= r_neg_r;
      end
   end

   assign w_prod = r_neg_p ? -w_acc_nxt : w_acc_nxt;
   assign w_quo  = r_neg_p ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
`else
   logic w_unused_signed;

   assign w_unused_signed = i_signed;
   assign w_a_mag         = i_a;
   assign w_b_mag         = i_b;
   assign w_prod          = w_acc_nxt;
   assign w_quo           = w_acc_nxt[WIDTH-1:0];
   assign w_rem           = w_acc_nxt[2*WIDTH-1:WIDTH];
`endif

   muldiv_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_accept && !w_dz),
      .i_step     (r_state == ST_RUN),
      .i_div_mode (r_op[1]),
      .i_a        (w_a_mag),
      .i_b        (w_b_mag),
      .o_acc_nxt  (w_acc_nxt)
   );

   // Result selection from the value the final iteration produces.
   always_comb begin
      w_res = {WIDTH{1'b0}};
      case (r_op)
         OP_MUL_LO: w_res = w_prod[WIDTH-1:0];
         OP_MUL_HI: w_res = w_prod[2*WIDTH-1:WIDTH];
         OP_DIV_Q:  w_res = w_quo;
         OP_DIV_R:  w_res = w_rem;
         default:   w_res = {WIDTH{1'b0}};
      endcase
   end

   // Next-state logic; a divide by zero skips the iteration phase.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               if (w_dz) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, counter, handshake outputs and result/flag registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_count  <= {CW{1'b0}};
         r_op     <= OP_MUL_LO;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= {WIDTH{1'b0}};
         r_flags  <= {FLAG_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_accept) begin
            r_count <= {CW{1'b0}};
            r_op    <= op_e'(i_op);
         end else if (r_state == ST_RUN) begin
            r_count <= r_count + CW'(1);
         end else begin
            r_count <= r_count;
         end
         if (w_dz) begin
            r_result <= w_res_dz;
            r_flags  <= make_flags(w_res_dz, 1'b1);
         end else if ((r_state == ST_RUN) && w_last) begin
            r_result <= w_res;
            r_flags  <= make_flags(w_res, 1'b0);
         end else begin
            r_result <= r_result;
            r_flags  <= r_flags;
         end
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;
   assign o_flags  = r_flags;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          sgn   = 1'b0;
   logic [1:0]    op    = 2'b00;
   logic [W-1:0]  a     = '0;
   logic [W-1:0]  b     = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [2:0]    flags;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [18:0]   exp_last    = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_start  (start),
      .i_op     (op),
      .i_signed (sgn),
      .i_a      (a),
      .i_b      (b),
      .o_busy   (busy),
      .o_done   (done),
      .o_result (result),
      .o_flags  (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {Z, N, DZ, result} from plain integer arithmetic.
   function automatic logic [18:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb, input logic msg);
      logic [31:0]  prod;
      logic [W-1:0] q, r, res;
      logic         dz, use_s;
      int           sa, sb;
      use_s = 1'b0;
`ifdef MULDIV_SIGNED_EN
      use_s = msg;
`endif
      sa   = use_s ? int'($signed(ma)) : int'(ma);
      sb   = use_s ? int'($signed(mb)) : int'(mb);
      prod = 32'(sa * sb);
      dz   = 1'b0;
      if (mb == '0) begin
         q  = '1;
         r  = ma;
         dz = mop[1];
      end else begin
         q = 16'(sa / sb);
         r = 16'(sa % sb);
      end
      case (mop)
         2'd0:    res = prod[15:0];
         2'd1:    res = prod[31:16];
         2'd2:    res = q;
         default: res = r;
      endcase
      return {(res == '0), res[W-1], dz, res};
   endfunction

   // Called at a negedge; returns at the negedge where Done is seen.
   task automatic run_op(input logic [1:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input int p1, input int p2, input string tag);
      logic [18:0] exp;
      int          n, nbusy;
      logic        seen, is_dz;
      exp      = model(top, ta, tb_v, ts);
      exp_last = exp;
      is_dz    = top[1] && (tb_v == '0);
      op = top; a = ta; b = tb_v; sgn = ts; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; nbusy = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) nbusy++;
            if (n == p1 || n == p2) begin
               start = 1'b1;
               op    = 2'($urandom);
               a     = W'($urandom);
               b     = W'($urandom);
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check({tag, "/latency"}, 32'(n), is_dz ? 32'd1 : 32'd17);
      check({tag, "/busy_cycles"}, 32'(nbusy), is_dz ? 32'd0 : 32'd16);
      check({tag, "/result"}, 32'(result), 32'(exp[15:0]));
      check({tag, "/flags"}, 32'(flags), 32'(exp[18:16]));
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "/done_drop"}, 32'({busy, done}), 32'd0);
      check({tag, "/result_hold"}, 32'(result), 32'(exp_last[15:0]));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dcount;
      #2 rst_n = 1'b0;
      #1;
      check("reset/state", 32'({busy, done, flags, result}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b00, 16'h0123, 16'h0045, 1'b0, 0, 0, "mul_lo");  idle_check("mul_lo");
      run_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, "mul_hi");  idle_check("mul_hi");
      run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, "mul_lo2"); idle_check("mul_lo2");
      run_op(2'b10, 16'h03E8, 16'h0007, 1'b0, 0, 0, "div_q");   idle_check("div_q");
      run_op(2'b11, 16'h03E8, 16'h0007, 1'b0, 0, 0, "div_r");   idle_check("div_r");
      run_op(2'b10, 16'h1234, 16'h0000, 1'b0, 0, 0, "dz_q");    idle_check("dz_q");
      run_op(2'b11, 16'h1234, 16'h0000, 1'b0, 0, 0, "dz_r");    idle_check("dz_r");
      run_op(2'b00, 16'h1234, 16'h0056, 1'b0, 5, 15, "ignore"); idle_check("ignore");
      run_op(2'b00, 16'h0000, 16'h5555, 1'b0, 0, 0, "zero");    idle_check("zero");
      run_op(2'b10, 16'h8000, 16'hFFFF, 1'b1, 0, 0, "minneg_q"); idle_check("minneg_q");
      run_op(2'b11, 16'h8000, 16'hFFFF, 1'b1, 0, 0, "minneg_r"); idle_check("minneg_r");

      // Back-to-back: Start held through DONE, including a divide-by-zero.
      run_op(2'b10, 16'h03E8, 16'h0007, 1'b0, 0, 0, "b2b_a");
      run_op(2'b11, 16'hBEEF, 16'h0000, 1'b0, 0, 0, "b2b_b");
      run_op(2'b01, 16'h1357, 16'h2468, 1'b0, 0, 0, "b2b_c");
      idle_check("b2b_c");

      // Reset in the middle of an operation.
      op = 2'b00; a = 16'h00FF; b = 16'h0101; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset/outputs", 32'({busy, done, flags, result}), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      check("midreset/no_done", 32'(dcount), 32'd0);
      run_op(2'b00, 16'h00FF, 16'h0101, 1'b0, 0, 0, "post_reset"); idle_check("post_reset");

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] rb;
         rb = W'($urandom);
         if ($urandom_range(7) == 0) rb = '0;
         run_op(2'($urandom), W'($urandom), rb, 1'($urandom), 0, 0, "rand");
         if ($urandom_range(1) == 1) idle_check("rand");
      end
      idle_check("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
